issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
- In-order issue buffer between rename and the issue bus. Accepts one renamed instruction per cycle from rename and holds up to DEPTH entries.
- Drives at most one entry per cycle onto the issue bus (address, immediate, src_1, src_2, arn, rrn, jump, tag, st_type, instr_name), consumed by the reservation stations and the ROB.
- Stalls on ROB or target-station back-pressure.
- Handles full flush and speculative (tag) squash or commit on branch resolution.

Parameters:
- XLEN, 32, address/immediate width
- DEPTH, 8, buffer entries; power of two, >= 2
- ST_COUNT, 4, number of reservation stations; width of station_full, indexed by integer value of st_type_e

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  rename presents an instruction
- in_ready  output  1  buffer can accept (count < DEPTH)
- in_address  input  XLEN  instruction address
- in_immediate  input  XLEN  immediate
- in_src_1, in_src_2, in_arn, in_rrn  input  6 each  register numbers
- in_jump  input  1  control-transfer instruction
- in_tag  input  1  speculative (behind unresolved branch)
- in_st_type  input  st_type_e  target station
- in_instr_name  input  instr_name_e  opcode
- rob_full  input  1  ROB cannot accept
- station_full  input  ST_COUNT  per-station full
- flush  input  1  discard everything
- resolve_valid  input  1  branch resolved this cycle
- resolve_mispredict  input  1  qualifies resolve_valid
- issue_valid  output  1  bus carries an instruction this cycle
- address, immediate  output  XLEN each  issue bus
- src_1, src_2, arn, rrn  output  6 each  issue bus
- jump, tag  output  1 each  issue bus
- st_type  output  st_type_e  issue bus
- instr_name  output  instr_name_e  issue bus
- count  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - Reset (any time, including mid-operation): pointers and count = 0, in_ready = 1, issue_valid = 0.
  - Bus idle values after reset: address, immediate, src_*, arn, rrn = 0; jump = 0; tag = 0; st_type = XX; instr_name = UNKNOWN.
- Push:
  - A push occurs on in_valid & in_ready at a rising edge; the entry is written at the tail.
  - in_ready is derived from registered count only; it is not raised by a same-cycle pop.
- Issue condition, evaluated combinationally on the head entry: count != 0 & !rob_full & (head.st_type == XX | !station_full[head.st_type]) & !flush & !(resolve_valid & resolve_mispredict & head.tag).
- Issue action:
  - On an issue, the head fields are registered onto the bus at the edge, issue_valid = 1 for exactly one cycle, and the head pops.
  - Otherwise, at that edge the bus returns to idle values and issue_valid = 0.
- Latency: an entry pushed at edge E0 into an empty buffer is visible on the bus after edge E1 at the earliest. Throughput is 1 per cycle.
- Ordering: strictly in-order. A blocked head blocks all younger entries.
- Tag invariant: upstream guarantees tagged entries form a contiguous segment at the tail.
- Branch resolve, correct prediction (resolve_valid & !resolve_mispredict):
  - All stored tag bits clear to 0.
  - A same-cycle push is stored with tag = 0.
  - A same-cycle issued head drives tag = 0.
- Branch resolve, misprediction (resolve_valid & resolve_mispredict):
  - The tail rewinds to the first tagged entry; count becomes the untagged count.
  - A same-cycle push is discarded.
  - An untagged head may still issue that cycle.
- Flush (synchronous, priority over all else): count = 0, pointers = 0, push discarded, bus idle and issue_valid = 0 next cycle.
- Simultaneous push and pop (not full): count unchanged.
- Pointers wrap modulo DEPTH.
- An issue_valid pulse already on the bus is not retracted by a later flush or mispredict; the ROB handles that case.

Test Plan:
- Reset then push A (address=0x100, st_type=ALU, tag=0) -> after the next edge issue_valid=1 with address=0x100, count=0; following cycle bus idle (instr_name=UNKNOWN, st_type=XX).
- Push 8 entries with rob_full=1 -> count=8, in_ready=0, 9th push ignored; drop rob_full -> 8 consecutive issue_valid pulses in push order.
- Head st_type=LOAD with station_full[LOAD]=1, next entry ALU -> nothing issues until station_full[LOAD]=0, then LOAD issues before ALU.
- Entries 0x10 (tag=0), 0x14 (tag=1), 0x18 (tag=1) with rob_full=1; pulse resolve mispredict -> count=1; release -> only 0x10 issues.
- Same setup with resolve correct -> all three issue with tag=0.
- Buffer holding 5 entries; assert flush with in_valid=1 -> count=0 next cycle, no issue; deassert reset_n mid-stream -> outputs reach idle values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/issue_scheduler_if.sv
// Shared opcode/station types and the rename-to-issue-bus interface of the issue scheduler.
package issue_scheduler_pkg;
  typedef enum logic [1:0] {XX = 2'd0, ALU = 2'd1, LOAD = 2'd2, STORE = 2'd3} st_type_e;
  typedef enum logic [2:0] {UNKNOWN = 3'd0, ADD, SUB, LW, SW, BEQ, JAL, LUI} instr_name_e;
endpackage

interface issue_scheduler_if #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 8,
  parameter int ST_COUNT = 4
);
  import issue_scheduler_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                in_valid, in_ready;
  logic [XLEN-1:0]     in_address, in_immediate;
  logic [5:0]          in_src_1, in_src_2, in_arn, in_rrn;
  logic                in_jump, in_tag;
  st_type_e            in_st_type;
  instr_name_e         in_instr_name;
  logic                rob_full;
  logic [ST_COUNT-1:0] station_full;
  logic                flush, resolve_valid, resolve_mispredict;
  logic                issue_valid;
  logic [XLEN-1:0]     address, immediate;
  logic [5:0]          src_1, src_2, arn, rrn;
  logic                jump, tag;
  st_type_e            st_type;
  instr_name_e         instr_name;
  logic [CW-1:0]       count;

  modport slave (
    input  in_valid, in_address, in_immediate, in_src_1, in_src_2, in_arn, in_rrn,
           in_jump, in_tag, in_st_type, in_instr_name, rob_full, station_full,
           flush, resolve_valid, resolve_mispredict,
    output in_ready, issue_valid, address, immediate, src_1, src_2, arn, rrn,
           jump, tag, st_type, instr_name, count
  );
  modport master (
    output in_valid, in_address, in_immediate, in_src_1, in_src_2, in_arn, in_rrn,
           in_jump, in_tag, in_st_type, in_instr_name, rob_full, station_full,
           flush, resolve_valid, resolve_mispredict,
    input  in_ready, issue_valid, address, immediate, src_1, src_2, arn, rrn,
           jump, tag, st_type, instr_name, count
  );
endinterface

// File: rtl/issue_scheduler.sv
// In-order issue buffer: circular queue of renamed instructions, one registered issue per cycle,
// with flush and speculative-tag squash/commit on branch resolution.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 8,
  parameter int ST_COUNT = 4
) (
  input logic               clk,
  input logic               reset_n,
  issue_scheduler_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] immediate;
    logic [5:0]      src_1, src_2, arn, rrn;
    logic            jump, tag;
    st_type_e        st_type;
    instr_name_e     instr_name;
  } entry_t;

  localparam entry_t IDLE = '0;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt, keep;
  logic          issue_vld;
  entry_t        bus_q, hd, hd_out, in_e;
  logic          in_ready, push, pop, mis, cor, st_blocked;

  assign mis      = bus.resolve_valid & bus.resolve_mispredict;
  assign cor      = bus.resolve_valid & ~bus.resolve_mispredict;
  assign in_ready = (cnt < CW'(DEPTH));
  assign push     = bus.in_valid & in_ready & ~bus.flush & ~mis;

  always_comb begin
    hd         = mem[head];
    st_blocked = (hd.st_type != XX) && bus.station_full[hd.st_type];
    pop        = (cnt != '0) & ~bus.rob_full & ~st_blocked & ~bus.flush & ~(mis & hd.tag);
    hd_out     = hd;
    if (cor) hd_out.tag = 1'b0;
    in_e = '{address: bus.in_address, immediate: bus.in_immediate,
             src_1: bus.in_src_1, src_2: bus.in_src_2, arn: bus.in_arn, rrn: bus.in_rrn,
             jump: bus.in_jump, tag: bus.in_tag & ~cor,
             st_type: bus.in_st_type, instr_name: bus.in_instr_name};
  end

  // Tagged entries sit contiguously at the tail, so the untagged ones are a prefix from head.
  always_comb begin
    keep = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((CW'(i) < cnt) && !mem[head + PW'(i)].tag) keep = keep + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (cor && !bus.flush)
      for (int i = 0; i < DEPTH; i++) mem[i].tag <= 1'b0;
    if (push) mem[tail] <= in_e;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      issue_vld <= 1'b0;
      bus_q     <= IDLE;
    end else if (bus.flush) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      issue_vld <= 1'b0;
      bus_q     <= IDLE;
    end else begin
      issue_vld <= pop;
      bus_q     <= pop ? hd_out : IDLE;
      head      <= head + PW'(pop);
      if (mis) begin
        tail <= head + keep[PW-1:0];
        cnt  <= keep - CW'(pop);
      end else begin
        tail <= tail + PW'(push);
        cnt  <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.issue_valid = issue_vld;
  assign bus.address     = bus_q.address;
  assign bus.immediate   = bus_q.immediate;
  assign bus.src_1       = bus_q.src_1;
  assign bus.src_2       = bus_q.src_2;
  assign bus.arn         = bus_q.arn;
  assign bus.rrn         = bus_q.rrn;
  assign bus.jump        = bus_q.jump;
  assign bus.tag         = bus_q.tag;
  assign bus.st_type     = bus_q.st_type;
  assign bus.instr_name  = bus_q.instr_name;
  assign bus.count       = cnt;
endmodule

// File: tb/tb_issue_scheduler.sv
// Randomized bench for issue_scheduler: queue-based reference model feeds an expected-issue
// scoreboard that a negedge monitor drains.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] address, immediate;
    logic [5:0]  s1, s2, arn, rrn;
    logic        jump, tag;
    st_type_e    st;
    instr_name_e nm;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  issue_scheduler_if #(.XLEN(32), .DEPTH(DEPTH), .ST_COUNT(4)) bif ();
  issue_scheduler #(.XLEN(32), .DEPTH(DEPTH), .ST_COUNT(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bif.slave));

  ent_t mq[$];
  ent_t exp_q[$];
  ent_t cur_in;
  int   errors = 0;
  int   checks = 0;
  logic in_spec = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pack_ent(input ent_t e);
    return {33'd0, e.address, e.immediate, e.s1, e.s2, e.arn, e.rrn, e.jump, e.tag, e.st, e.nm};
  endfunction

  function automatic logic [127:0] bus_val();
    return {33'd0, bif.address, bif.immediate, bif.src_1, bif.src_2, bif.arn, bif.rrn,
            bif.jump, bif.tag, bif.st_type, bif.instr_name};
  endfunction

  function automatic ent_t mk(input logic [31:0] a, input st_type_e st, input logic tg);
    ent_t e;
    e.address = a;            e.immediate = $urandom;
    e.s1 = 6'($urandom);      e.s2 = 6'($urandom);
    e.arn = 6'($urandom);     e.rrn = 6'($urandom);
    e.jump = 1'($urandom);    e.tag = tg;
    e.st = st;                e.nm = instr_name_e'(3'($urandom_range(1, 7)));
    return e;
  endfunction

  // Drive current inputs, predict the edge from the rules, then commit just after it.
  task automatic tick();
    ent_t nq[$];
    ent_t e;
    logic fl, mis, cor, psh, iss;
    bif.in_address = cur_in.address;  bif.in_immediate = cur_in.immediate;
    bif.in_src_1 = cur_in.s1;         bif.in_src_2 = cur_in.s2;
    bif.in_arn = cur_in.arn;          bif.in_rrn = cur_in.rrn;
    bif.in_jump = cur_in.jump;        bif.in_tag = cur_in.tag;
    bif.in_st_type = cur_in.st;       bif.in_instr_name = cur_in.nm;
    nq  = mq;
    fl  = bif.flush;
    mis = bif.resolve_valid & bif.resolve_mispredict;
    cor = bif.resolve_valid & ~bif.resolve_mispredict;
    psh = bif.in_valid && (mq.size() < DEPTH);
    iss = 1'b0;
    if (!fl && nq.size() > 0 && !bif.rob_full &&
        (nq[0].st == XX || !bif.station_full[nq[0].st]) && !(mis && nq[0].tag)) iss = 1'b1;
    if (fl) nq.delete();
    else begin
      if (iss) begin
        e = nq.pop_front();
        if (cor) e.tag = 1'b0;
      end
      if (mis) begin
        while (nq.size() > 0 && nq[nq.size()-1].tag) void'(nq.pop_back());
      end else begin
        if (cor) foreach (nq[i]) nq[i].tag = 1'b0;
        if (psh) begin
          ent_t p = cur_in;
          if (cor) p.tag = 1'b0;
          nq.push_back(p);
        end
      end
    end
    @(posedge clk);
    #1;
    mq = nq;
    if (iss) exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bif.in_valid = 0; bif.rob_full = 0; bif.station_full = '0; bif.flush = 0;
    bif.resolve_valid = 0; bif.resolve_mispredict = 0;
  endtask

  task automatic push1(input ent_t e);
    cur_in = e; bif.in_valid = 1; tick(); bif.in_valid = 0;
  endtask

  task automatic tag_scenario(input logic mispredict);
    bif.rob_full = 1;
    push1(mk(32'h10, ALU, 0));
    push1(mk(32'h14, ALU, 1));
    push1(mk(32'h18, LOAD, 1));
    bif.resolve_valid = 1; bif.resolve_mispredict = mispredict; tick();
    bif.resolve_valid = 0; bif.resolve_mispredict = 0; bif.rob_full = 0;
    repeat (5) tick();
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("count", 128'(bif.count), 128'(mq.size()));
      chk("in_ready", 128'(bif.in_ready), 128'(mq.size() < DEPTH));
      if (bif.issue_valid) begin
        if (exp_q.size() == 0) chk("spurious_issue", 128'(1), 128'(0));
        else chk("issue_bus", bus_val(), pack_ent(exp_q.pop_front()));
      end else begin
        chk("issue_missing", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        chk("idle_bus", bus_val(), 128'(0));
      end
    end
  end

  initial begin
    reset_n = 0;
    idle_inputs();
    cur_in = mk(32'h0, XX, 0);
    #12;
    chk("rst_count", 128'(bif.count), 128'(0));
    chk("rst_in_ready", 128'(bif.in_ready), 128'(1));
    chk("rst_issue_valid", 128'(bif.issue_valid), 128'(0));
    chk("rst_idle_bus", bus_val(), 128'(0));
    reset_n = 1;

    push1(mk(32'h100, ALU, 0));
    repeat (3) tick();

    bif.rob_full = 1;
    for (int i = 0; i < 9; i++) push1(mk(32'h200 + 32'(4 * i), st_type_e'(2'($urandom)), 0));
    tick();
    bif.rob_full = 0;
    repeat (10) tick();

    bif.station_full = 4'b0100;
    push1(mk(32'h300, LOAD, 0));
    push1(mk(32'h304, ALU, 0));
    repeat (3) tick();
    bif.station_full = '0;
    repeat (4) tick();

    tag_scenario(1'b1);
    tag_scenario(1'b0);

    bif.rob_full = 1;
    for (int i = 0; i < 5; i++) push1(mk(32'h400 + 32'(4 * i), ALU, 0));
    cur_in = mk(32'h500, ALU, 0);
    bif.in_valid = 1; bif.flush = 1; tick();
    bif.in_valid = 0; bif.flush = 0; bif.rob_full = 0;
    repeat (3) tick();

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) in_spec = 1'b1;
      cur_in = mk($urandom, st_type_e'(2'($urandom)), in_spec);
      bif.in_valid = ($urandom_range(0, 9) < 7);
      bif.rob_full = ($urandom_range(0, 3) == 0);
      bif.station_full = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      bif.resolve_valid = ($urandom_range(0, 11) == 0);
      bif.resolve_mispredict = 1'($urandom);
      bif.flush = ($urandom_range(0, 39) == 0);
      if (bif.resolve_valid || bif.flush) in_spec = 1'b0;
      tick();
    end
    idle_inputs();

    bif.rob_full = 1;
    for (int i = 0; i < 4; i++) push1(mk(32'h600 + 32'(4 * i), ALU, 0));
    bif.rob_full = 0;
    tick();
    #2;
    reset_n = 0;
    #1;
    chk("async_rst_issue_valid", 128'(bif.issue_valid), 128'(0));
    chk("async_rst_count", 128'(bif.count), 128'(0));
    chk("async_rst_in_ready", 128'(bif.in_ready), 128'(1));
    chk("async_rst_idle_bus", bus_val(), 128'(0));
    mq.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1;
    repeat (3) tick();
    push1(mk(32'h700, STORE, 0));
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
